// File: rtl/booth_arb_pkg.sv
// rtl/booth_arb_pkg.sv - shared types and defaults for the Booth core arbiter
package booth_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int DEF_NREQ    = 4;
  localparam int DEF_W       = 8;
  localparam int DEF_TIMEOUT = 64;

  // Requester index width; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/booth_rr_pick.sv
// rtl/booth_rr_pick.sv - combinational round-robin one-hot picker
module booth_rr_pick
  import booth_arb_pkg::*;
#(
  parameter  int NREQ = DEF_NREQ,
  localparam int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_grant,
  output logic [NREQ-1:0] onehot,
  output logic [IW-1:0]   idx,
  output logic            any
);

  // First requester after last_grant, wrapping, so the last winner ranks lowest.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!any && req[(int'(last_grant) + k) % NREQ]) begin
        any = 1'b1;
        onehot[(int'(last_grant) + k) % NREQ] = 1'b1;
        idx = IW'((int'(last_grant) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/booth_mul_arbiter.sv
// rtl/booth_mul_arbiter.sv - round-robin sharing of one Booth core; BOOTH_ARB_TIMEOUT_EN bounds WAIT
module booth_mul_arbiter
  import booth_arb_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int W       = DEF_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [2*W-1:0]    rsp_prod,
  output logic              rsp_err,
  output logic              mul_start,
  output logic [W-1:0]      mul_a,
  output logic [W-1:0]      mul_b,
  input  logic              mul_done,
  input  logic [2*W-1:0]    mul_prod,
  output logic              busy
);

  localparam int IW = idx_w(NREQ);

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, b_q;
  logic [IW-1:0]   g_q, last_q;
  logic [2*W-1:0]  prod_q;
  logic [NREQ-1:0] pick_oh;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic            timeout_hit;

  booth_rr_pick #(.NREQ(NREQ)) u_pick (
    .req        (req_valid),
    .last_grant (last_q),
    .onehot     (pick_oh),
    .idx        (pick_idx),
    .any        (pick_any)
  );

`ifdef BOOTH_ARB_TIMEOUT_EN
  logic [W-1:0] cnt_q;
  logic         err_q;

  assign timeout_hit = (cnt_q == W'(TIMEOUT - 1));
  assign rsp_err     = err_q;

  // WAIT cycle counter and abort flag; a done on the abort cycle still wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE:  if (pick_any) err_q <= 1'b0;
        ISSUE: cnt_q <= '0;
        WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (mul_done)         err_q <= 1'b0;
          else if (timeout_hit) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT == 0);
  assign timeout_hit    = 1'b0;
  assign rsp_err        = 1'b0;
`endif

  assign mul_a    = a_q;
  assign mul_b    = b_q;
  assign rsp_prod = prod_q;

  // Next state and state-decoded handshake outputs.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    rsp_valid = '0;
    mul_start = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        busy      = 1'b0;
        req_ready = pick_oh;
        if (pick_any) state_d = ISSUE;
      end
      ISSUE: begin
        mul_start = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        if (mul_done || timeout_hit) state_d = RESP;
      end
      RESP: begin
        rsp_valid[g_q] = 1'b1;
        if (rsp_ready[g_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, operand/grant capture, product capture and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      g_q     <= '0;
      last_q  <= IW'(NREQ - 1);
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            a_q <= req_a[int'(pick_idx)*W +: W];
            b_q <= req_b[int'(pick_idx)*W +: W];
            g_q <= pick_idx;
          end
        end
        WAIT: begin
          if (mul_done)         prod_q <= mul_prod;
          else if (timeout_hit) prod_q <= '0;
        end
        RESP: begin
          if (rsp_ready[g_q]) last_q <= g_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// tb/tb_booth_mul_arbiter.sv - self-checking bench for booth_mul_arbiter
module tb_booth_mul_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;

  typedef struct {
    int         idx;
    logic [7:0] a;
    logic [7:0] b;
    logic [15:0] p;
  } vec_t;

  typedef struct {
    int          idx;
    logic [15:0] prod;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [3:0]  rsp_valid;
  logic [3:0]  rsp_ready = '0;
  logic [15:0] rsp_prod;
  logic        rsp_err;
  logic        mul_start;
  logic [7:0]  mul_a, mul_b;
  logic        mul_done = 1'b0;
  logic [15:0] mul_prod = '0;
  logic        busy;

  int n_checks = 0;
  int n_err    = 0;

  vec_t        tbl[8];
  exp_t        sb[$];
  exp_t        e;
  int          grant_log[$];
  logic [15:0] slot_exp[4];
  logic        slot_err[4];
  int          post_cnt[4];
  int          acc_seen[4];
  logic [3:0]  acc_last = '0;
  int          flush_cnt = 0, flush_seen = 0;

  int          start_cnt = 0;
  bit          core_silent = 1'b0;
  int          core_lat = 0;
  bit          pend = 1'b0;
  int          cd = 0;
  logic [15:0] pprod;
  logic signed [15:0] xa, xb;
  int          stray_cnt = 0, stray_seen = 0;
  logic [15:0] stray_val = '0;
  bit          hold_rsp = 1'b0;

  always #5 clk = ~clk;

  booth_mul_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_prod  (rsp_prod),
    .rsp_err   (rsp_err),
    .mul_start (mul_start),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_done  (mul_done),
    .mul_prod  (mul_prod),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Requester i holds valid while it has more posts than accepts.
  always_comb begin
    for (int i = 0; i < 4; i++) req_valid[i] = (post_cnt[i] != acc_seen[i]);
  end

  // Records which requester the DUT accepts on this edge (pre-edge values).
  always @(posedge clk) acc_last = rst_n ? (req_valid & req_ready) : 4'b0000;

  // Booth core stand-in: product after core_lat+1 cycles, or never when silent.
  always @(negedge clk) begin
    mul_done = 1'b0;
    if (pend) begin
      if (cd == 0) begin
        mul_done = 1'b1;
        mul_prod = pprod;
        pend     = 1'b0;
      end else begin
        cd--;
      end
    end
    if (stray_cnt != stray_seen) begin
      mul_done   = 1'b1;
      mul_prod   = stray_val;
      stray_seen = stray_cnt;
    end
    if (mul_start) begin
      start_cnt++;
      xa    = {{8{mul_a[7]}}, mul_a};
      xb    = {{8{mul_b[7]}}, mul_b};
      pprod = xa * xb;
      pend  = !core_silent;
      cd    = core_lat;
    end
  end

  // Scoreboard: push on accept, pop and compare on each response.
  always @(negedge clk) begin
    if (flush_cnt != flush_seen) begin
      sb.delete();
      flush_seen = flush_cnt;
    end
    for (int i = 0; i < 4; i++) begin
      if (acc_last[i]) begin
        sb.push_back('{idx: i, prod: slot_exp[i], err: slot_err[i]});
        grant_log.push_back(i);
        acc_seen[i]++;
      end
    end
    rsp_ready = '0;
    if (hold_rsp) begin
      rsp_ready = ~rsp_valid;
    end else if (rsp_valid != 4'b0000) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL rsp_unexpected: got rsp_valid=%b, want none", rsp_valid);
      end else begin
        e = sb.pop_front();
        chk("rsp_valid", 32'(rsp_valid), 32'(1) << e.idx);
        chk("rsp_prod", 32'(rsp_prod), 32'(e.prod));
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
      end
      rsp_ready = rsp_valid;
    end
  end

  task automatic post(input int i, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] p, input logic er);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
    slot_exp[i]     = p;
    slot_err[i]     = er;
    post_cnt[i]++;
  endtask

  task automatic wait_start(input string name, output int k);
    k = 0;
    while (!mul_start && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!mul_start) begin
      n_checks++;
      n_err++;
      $display("FAIL %s: got no mul_start in %0d cycles, want one", name, k);
    end
  endtask

  task automatic wait_rsp(input string name);
    int k;
    k = 0;
    while (rsp_valid == 4'b0000 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (rsp_valid == 4'b0000) begin
      n_checks++;
      n_err++;
      $display("FAIL %s: got no rsp_valid in %0d cycles, want one", name, k);
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    while ((sb.size() != 0 || req_valid != 4'b0000 || busy) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) begin
      n_checks++;
      n_err++;
      $display("FAIL %s: got busy after %0d cycles, want idle", name, k);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    flush_cnt++;
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, 32'({busy, req_ready, rsp_valid, rsp_err, mul_start, mul_a, mul_b}), 32'd0);
    chk({name, "_prod"}, 32'(rsp_prod), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end

  initial begin
    int k, s0, base, n;
    int order[5];

    tbl[0] = '{0, 8'd7,  8'hFD, 16'hFFEB};
    tbl[1] = '{1, 8'h80, 8'h80, 16'h4000};
    tbl[2] = '{2, 8'h7F, 8'h7F, 16'h3F01};
    tbl[3] = '{3, 8'hFF, 8'h01, 16'hFFFF};
    tbl[4] = '{0, 8'h00, 8'h55, 16'h0000};
    tbl[5] = '{1, 8'h80, 8'h7F, 16'hC080};
    tbl[6] = '{2, 8'd5,  8'd6,  16'h001E};
    tbl[7] = '{3, 8'hFE, 8'hFD, 16'h0006};
    order  = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 4; i++) begin
      post_cnt[i] = 0;
      acc_seen[i] = 0;
      slot_exp[i] = '0;
      slot_err[i] = 1'b0;
    end

    repeat (3) @(negedge clk);
    chk_all_zero("reset_state");
    rst_n = 1'b1;
    @(negedge clk);

    // Single request: latency, one start pulse, response timing.
    s0 = start_cnt;
    post(0, 8'd7, 8'hFD, 16'hFFEB, 1'b0);
    wait_start("t1_start", k);
    chk("t1_start_latency", 32'(k), 32'd1);
    chk("t1_mul_ab", 32'({mul_a, mul_b}), 32'h07FD);
    @(negedge clk);
    chk("t1_start_pulse", 32'(mul_start), 32'd0);
    chk("t1_rsp_early", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("t1_rsp_rise", 32'(rsp_valid), 32'b0001);
    wait_idle("t1_idle", 50);
    chk("t1_starts", 32'(start_cnt - s0), 32'd1);

    // Table: one request at a time across requesters and sign corners.
    for (int v = 0; v < 8; v++) begin
      post(tbl[v].idx, tbl[v].a, tbl[v].b, tbl[v].p, 1'b0);
      wait_start("tbl_start", k);
      chk("tbl_mul_ab", 32'({mul_a, mul_b}), 32'({tbl[v].a, tbl[v].b}));
      wait_idle("tbl_idle", 50);
    end

    // All four together from reset, then requester 0 again.
    pulse_reset();
    base = grant_log.size();
    for (int i = 0; i < 4; i++) post(i, tbl[4+i].a, tbl[4+i].b, tbl[4+i].p, 1'b0);
    k = 0;
    while (grant_log.size() == base && k < 20) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    post(0, 8'd3, 8'd4, 16'h000C, 1'b0);
    wait_idle("t2_idle", 200);
    chk("t2_grants", 32'(grant_log.size() - base), 32'd5);
    for (int j = 0; j < 5; j++) begin
      if (base + j < grant_log.size())
        chk("t2_order", 32'(grant_log[base+j]), 32'(order[j]));
    end

    // Response back-pressure: outputs hold, nothing new is accepted or started.
    hold_rsp = 1'b1;
    post(1, 8'h80, 8'h80, 16'h4000, 1'b0);
    wait_rsp("t3_rsp");
    s0 = start_cnt;
    post(2, 8'd5, 8'd6, 16'h001E, 1'b0);
    repeat (10) begin
      @(negedge clk);
      chk("t3_rsp_valid", 32'(rsp_valid), 32'b0010);
      chk("t3_rsp_prod", 32'(rsp_prod), 32'h4000);
      chk("t3_req_ready", 32'(req_ready), 32'd0);
      chk("t3_starts", 32'(start_cnt - s0), 32'd0);
    end
    hold_rsp = 1'b0;
    wait_idle("t3_idle", 80);

    // Stray done in IDLE leaves state and product alone.
    @(negedge clk);
    stray_val = 16'hBEEF;
    stray_cnt++;
    repeat (3) @(negedge clk);
    chk("t6_idle_busy", 32'(busy), 32'd0);
    chk("t6_idle_prod", 32'(rsp_prod), 32'h001E);

    // Stray done in RESP leaves the held product alone.
    hold_rsp = 1'b1;
    post(3, 8'hFF, 8'h01, 16'hFFFF, 1'b0);
    wait_rsp("t6_rsp");
    stray_val = 16'h1234;
    stray_cnt++;
    repeat (3) @(negedge clk);
    chk("t6_resp_valid", 32'(rsp_valid), 32'b1000);
    chk("t6_resp_prod", 32'(rsp_prod), 32'hFFFF);
    hold_rsp = 1'b0;
    wait_idle("t6_idle", 50);

    // Reset during WAIT aborts silently; next request is served normally.
    core_silent = 1'b1;
    post(1, 8'h7F, 8'h7F, 16'h3F01, 1'b0);
    wait_start("t4_start", k);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_all_zero("t4_reset");
    rst_n = 1'b1;
    flush_cnt++;
    core_silent = 1'b0;
    @(negedge clk);
    post(2, 8'hFE, 8'hFD, 16'h0006, 1'b0);
    wait_idle("t4_idle", 50);

`ifdef BOOTH_ARB_TIMEOUT_EN
    // Silent core: abort after 64 WAIT cycles with zero product and error.
    core_silent = 1'b1;
    post(0, 8'd3, 8'd4, 16'h0000, 1'b1);
    wait_start("t5_start", k);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rsp_valid == 4'b0000 && n < 200);
    chk("t5_timeout_cycles", 32'(n), 32'd65);
    wait_idle("t5_idle", 50);
    core_silent = 1'b0;

    // Done on the abort cycle wins.
    core_lat = 63;
    post(1, 8'd3, 8'd4, 16'h000C, 1'b0);
    wait_start("t5b_start", k);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rsp_valid == 4'b0000 && n < 200);
    chk("t5b_cycles", 32'(n), 32'd65);
    wait_idle("t5b_idle", 50);
    core_lat = 0;
`else
    // Without the timeout, a silent core keeps the arbiter in WAIT.
    core_silent = 1'b1;
    post(0, 8'd3, 8'd4, 16'h000C, 1'b0);
    n = 0;
    repeat (100) begin
      @(negedge clk);
      n++;
    end
    chk("t5_wait_busy", 32'(busy), 32'd1);
    chk("t5_wait_rsp", 32'({rsp_valid, rsp_err}), 32'd0);
    pulse_reset();
    core_silent = 1'b0;
    @(negedge clk);
    post(3, 8'd5, 8'd6, 16'h001E, 1'b0);
    wait_idle("t5_idle", 50);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
